// File: rtl/parking_keypad_if.sv
// Keypad/checker bundle for the parking entrance stage.
// master: keypad + password checker side (drives keys and verdicts, observes entry status).
// slave : parking_keypad (consumes keys/verdicts, presents password, strobe and status).
//   key_valid/key_code   one-cycle key strobe and code (0..9 digit, A clear, B enter)
//   ok_pass/wrong_pass   checker verdicts
//   pass_value/valid     20-bit binary password and one-cycle submit strobe
//   digit_count, entry_active, entry_error, locked, fail_count  entry status
interface parking_keypad_if;
  logic        key_valid;
  logic [3:0]  key_code;
  logic        ok_pass;
  logic        wrong_pass;
  logic [19:0] pass_value;
  logic        pass_valid;
  logic [2:0]  digit_count;
  logic        entry_active;
  logic        entry_error;
  logic        locked;
  logic [1:0]  fail_count;

  modport master (
    output key_valid, key_code, ok_pass, wrong_pass,
    input  pass_value, pass_valid, digit_count, entry_active, entry_error, locked, fail_count
  );

  modport slave (
    input  key_valid, key_code, ok_pass, wrong_pass,
    output pass_value, pass_valid, digit_count, entry_active, entry_error, locked, fail_count
  );
endinterface

// File: rtl/parking_keypad.sv
// Entrance keypad stage: accumulates decimal digits into a binary password,
// submits it to the checker with a one-cycle strobe, waits for the verdict,
// and enforces entry/verdict timeouts and a lockout after repeated rejections.
// Ports:
//   clk    system clock, rising edge
//   rst_n  asynchronous active-low reset
//   kp     parking_keypad_if.slave bundle (keys/verdicts in, password/status out)
module parking_keypad #(
  parameter int unsigned DIGITS         = 6,
  parameter int unsigned TIMEOUT_CYCLES = 1000,
  parameter int unsigned MAX_TRIES      = 3,
  parameter int unsigned LOCK_CYCLES    = 5000
) (
  input  logic             clk,
  input  logic             rst_n,
  parking_keypad_if.slave  kp
);

  localparam int unsigned PW_W    = 20;
  localparam int unsigned DC_W    = 3;
  localparam int unsigned FC_W    = 2;
  localparam int unsigned CNT_MAX = (LOCK_CYCLES > TIMEOUT_CYCLES) ? LOCK_CYCLES : TIMEOUT_CYCLES;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ENTRY,
    S_SUBMIT,
    S_WAIT,
    S_LOCKOUT
  } state_e;

  state_e            state_q, state_d;
  logic [PW_W-1:0]   pass_value_q, pass_value_d;
  logic [DC_W-1:0]   digit_count_q, digit_count_d;
  logic [FC_W-1:0]   fail_count_q, fail_count_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              pass_valid_q, pass_valid_d;
  logic              entry_active_q, entry_active_d;
  logic              entry_error_q, entry_error_d;
  logic              locked_q, locked_d;

  logic key_digit;
  logic key_clear;
  logic key_enter;

  assign key_digit = kp.key_valid && (kp.key_code < 4'd10);
  assign key_clear = kp.key_valid && (kp.key_code == 4'hA);
  assign key_enter = kp.key_valid && (kp.key_code == 4'hB);

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= S_IDLE;
      pass_value_q   <= '0;
      digit_count_q  <= '0;
      fail_count_q   <= '0;
      cnt_q          <= '0;
      pass_valid_q   <= 1'b0;
      entry_active_q <= 1'b0;
      entry_error_q  <= 1'b0;
      locked_q       <= 1'b0;
    end else begin
      state_q        <= state_d;
      pass_value_q   <= pass_value_d;
      digit_count_q  <= digit_count_d;
      fail_count_q   <= fail_count_d;
      cnt_q          <= cnt_d;
      pass_valid_q   <= pass_valid_d;
      entry_active_q <= entry_active_d;
      entry_error_q  <= entry_error_d;
      locked_q       <= locked_d;
    end
  end

  // Next-state logic; cnt_q is the shared idle / verdict / lockout timer
  always_comb begin
    state_d       = state_q;
    pass_value_d  = pass_value_q;
    digit_count_d = digit_count_q;
    fail_count_d  = fail_count_q;
    cnt_d         = cnt_q + CNT_W'(1);
    entry_error_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (key_digit) begin
          state_d       = S_ENTRY;
          pass_value_d  = PW_W'(kp.key_code);
          digit_count_d = DC_W'(1);
        end
      end

      S_ENTRY: begin
        if (kp.key_valid) begin
          cnt_d = '0;
          if (key_digit) begin
            // A digit beyond the password length is dropped silently
            if (digit_count_q < DC_W'(DIGITS)) begin
              pass_value_d  = PW_W'(pass_value_q * PW_W'(10)) + PW_W'(kp.key_code);
              digit_count_d = digit_count_q + DC_W'(1);
            end
          end else if (key_clear) begin
            state_d       = S_IDLE;
            pass_value_d  = '0;
            digit_count_d = '0;
          end else if (key_enter) begin
            if (digit_count_q == DC_W'(DIGITS)) begin
              state_d = S_SUBMIT;
            end else begin
              state_d       = S_IDLE;
              pass_value_d  = '0;
              digit_count_d = '0;
              entry_error_d = 1'b1;
            end
          end
        end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          state_d       = S_IDLE;
          pass_value_d  = '0;
          digit_count_d = '0;
          entry_error_d = 1'b1;
        end
      end

      S_SUBMIT: begin
        state_d = S_WAIT;
        cnt_d   = '0;
      end

      S_WAIT: begin
        // ok_pass takes priority over a simultaneous wrong_pass
        if (kp.ok_pass) begin
          state_d       = S_IDLE;
          fail_count_d  = '0;
          pass_value_d  = '0;
          digit_count_d = '0;
        end else if (kp.wrong_pass) begin
          fail_count_d  = fail_count_q + FC_W'(1);
          pass_value_d  = '0;
          digit_count_d = '0;
          cnt_d         = '0;
          state_d       = (fail_count_q == FC_W'(MAX_TRIES - 1)) ? S_LOCKOUT : S_IDLE;
        end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          state_d       = S_IDLE;
          pass_value_d  = '0;
          digit_count_d = '0;
          entry_error_d = 1'b1;
        end
      end

      S_LOCKOUT: begin
        if (cnt_q == CNT_W'(LOCK_CYCLES - 1)) begin
          state_d      = S_IDLE;
          fail_count_d = '0;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Status outputs are registered copies decoded from the next state
    pass_valid_d   = (state_d == S_SUBMIT);
    entry_active_d = (state_d == S_ENTRY) || (state_d == S_SUBMIT) || (state_d == S_WAIT);
    locked_d       = (state_d == S_LOCKOUT);
  end

  assign kp.pass_value   = pass_value_q;
  assign kp.pass_valid   = pass_valid_q;
  assign kp.digit_count  = digit_count_q;
  assign kp.entry_active = entry_active_q;
  assign kp.entry_error  = entry_error_q;
  assign kp.locked       = locked_q;
  assign kp.fail_count   = fail_count_q;

endmodule

// File: tb/tb_parking_keypad.sv
// Bench for parking_keypad: directed key/verdict sequences, a queue-based
// behavioural model compared every cycle, and literal spot checks.
module tb_parking_keypad;

  localparam int unsigned DIGITS    = 6;
  localparam int unsigned TIMEOUT   = 16;
  localparam int unsigned MAX_TRIES = 3;
  localparam int unsigned LOCK      = 32;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  parking_keypad_if kp();

  parking_keypad #(
    .DIGITS         (DIGITS),
    .TIMEOUT_CYCLES (TIMEOUT),
    .MAX_TRIES      (MAX_TRIES),
    .LOCK_CYCLES    (LOCK)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .kp    (kp)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: the entry is a list of digits; the password is its decimal value
  int m_dq[$];
  bit m_sub   = 1'b0;
  bit m_wait  = 1'b0;
  bit m_err   = 1'b0;
  int m_age   = 0;
  int m_idle  = 0;
  int m_lock  = 0;
  int m_fails = 0;

  function automatic int fold();
    int v = 0;
    foreach (m_dq[i]) v = v * 10 + m_dq[i];
    return v;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_dq.delete();
      m_sub = 0; m_wait = 0; m_err = 0;
      m_age = 0; m_idle = 0; m_lock = 0; m_fails = 0;
    end else begin
      m_err = 0;
      if (m_lock > 0) begin
        m_lock--;
        if (m_lock == 0) m_fails = 0;
      end else if (m_sub) begin
        m_sub  = 0;
        m_wait = 1;
        m_age  = 0;
      end else if (m_wait) begin
        if (kp.ok_pass) begin
          m_fails = 0; m_dq.delete(); m_wait = 0;
        end else if (kp.wrong_pass) begin
          m_fails++; m_dq.delete(); m_wait = 0;
          if (m_fails == MAX_TRIES) m_lock = LOCK;
        end else begin
          m_age++;
          if (m_age == TIMEOUT) begin
            m_err = 1; m_dq.delete(); m_wait = 0;
          end
        end
      end else if (m_dq.size() > 0) begin
        if (kp.key_valid) begin
          m_idle = 0;
          if (kp.key_code < 10) begin
            if (m_dq.size() < DIGITS) m_dq.push_back(int'(kp.key_code));
          end else if (kp.key_code == 4'hA) begin
            m_dq.delete();
          end else if (kp.key_code == 4'hB) begin
            if (m_dq.size() == DIGITS) m_sub = 1;
            else begin
              m_err = 1; m_dq.delete();
            end
          end
        end else begin
          m_idle++;
          if (m_idle == TIMEOUT) begin
            m_err = 1; m_dq.delete();
          end
        end
      end else if (kp.key_valid && kp.key_code < 10) begin
        m_dq.push_back(int'(kp.key_code));
        m_idle = 0;
      end
    end
  end

  always @(negedge clk) begin
    check("pass_value",   int'(kp.pass_value),   fold());
    check("digit_count",  int'(kp.digit_count),  m_dq.size());
    check("pass_valid",   int'(kp.pass_valid),   int'(m_sub));
    check("entry_active", int'(kp.entry_active), int'(m_dq.size() > 0));
    check("entry_error",  int'(kp.entry_error),  int'(m_err));
    check("locked",       int'(kp.locked),       int'(m_lock > 0));
    check("fail_count",   int'(kp.fail_count),   m_fails);
  end

  task automatic press(input logic [3:0] c);
    kp.key_code  = c;
    kp.key_valid = 1'b1;
    @(negedge clk);
    kp.key_valid = 1'b0;
    kp.key_code  = 4'h0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic type_number(input int unsigned v, input int n);
    int unsigned p = 1;
    for (int i = 1; i < n; i++) p = p * 10;
    for (int i = 0; i < n; i++) begin
      press(4'((v / p) % 10));
      p = p / 10;
    end
  endtask

  task automatic verdict(input bit ok, input bit wr);
    kp.ok_pass    = ok;
    kp.wrong_pass = wr;
    @(negedge clk);
    kp.ok_pass    = 1'b0;
    kp.wrong_pass = 1'b0;
  endtask

  task automatic submit_wrong(input int unsigned v);
    type_number(v, 6);
    press(4'hB);
    idle(1);
    verdict(1'b0, 1'b1);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_pass_value"},   int'(kp.pass_value),   0);
    check({tag, "_pass_valid"},   int'(kp.pass_valid),   0);
    check({tag, "_digit_count"},  int'(kp.digit_count),  0);
    check({tag, "_entry_active"}, int'(kp.entry_active), 0);
    check({tag, "_entry_error"},  int'(kp.entry_error),  0);
    check({tag, "_locked"},       int'(kp.locked),       0);
    check({tag, "_fail_count"},   int'(kp.fail_count),   0);
  endtask

  initial begin
    kp.key_valid  = 1'b0;
    kp.key_code   = 4'h0;
    kp.ok_pass    = 1'b0;
    kp.wrong_pass = 1'b0;
    idle(2);
    check_reset_values("reset");
    rst_n = 1'b1;
    idle(1);

    // Full six-digit entry, submit, accepted
    type_number(123456, 6);
    check("t1_count", int'(kp.digit_count), 6);
    press(4'hB);
    check("t1_strobe", int'(kp.pass_valid), 1);
    check("t1_value", int'(kp.pass_value), 123456);
    idle(1);
    check("t1_strobe_len", int'(kp.pass_valid), 0);
    check("t1_value_held", int'(kp.pass_value), 123456);
    verdict(1'b1, 1'b0);
    check("t1_cleared", int'(kp.pass_value), 0);
    check("t1_idle", int'(kp.entry_active), 0);

    // Short entry, then overlong entry with the seventh digit dropped
    type_number(987, 3);
    press(4'hB);
    check("t2_error", int'(kp.entry_error), 1);
    check("t2_count", int'(kp.digit_count), 0);
    check("t2_fails", int'(kp.fail_count), 0);
    idle(1);
    check("t2_error_len", int'(kp.entry_error), 0);
    type_number(1234567, 7);
    check("t2_count7", int'(kp.digit_count), 6);
    press(4'hB);
    check("t2_value", int'(kp.pass_value), 123456);
    idle(1);
    verdict(1'b1, 1'b0);

    // Ignored codes in IDLE, clear in ENTRY, leading zeros
    press(4'hD);
    press(4'hB);
    check("t3_ignored", int'(kp.entry_active), 0);
    type_number(55, 2);
    press(4'hA);
    check("t3_clear", int'(kp.digit_count), 0);
    check("t3_no_err", int'(kp.entry_error), 0);
    type_number(1, 6);
    press(4'hB);
    check("t3_value", int'(kp.pass_value), 1);
    idle(1);
    verdict(1'b1, 1'b0);

    // Entry timeout and clean restart
    press(4'h4);
    idle(15);
    check("t4_alive", int'(kp.entry_active), 1);
    idle(1);
    check("t4_timeout", int'(kp.entry_error), 1);
    check("t4_count", int'(kp.digit_count), 0);
    press(4'h7);
    check("t4_restart", int'(kp.pass_value), 7);
    check("t4_restart_cnt", int'(kp.digit_count), 1);
    press(4'hA);

    // Verdict timeout leaves fail_count alone
    type_number(222222, 6);
    press(4'hB);
    idle(16);
    check("t4_wait_alive", int'(kp.entry_active), 1);
    idle(1);
    check("t4_wait_timeout", int'(kp.entry_error), 1);
    check("t4_wait_fails", int'(kp.fail_count), 0);

    // Three rejections -> lockout, keys ignored, recovery
    submit_wrong(111111);
    check("t5_fail1", int'(kp.fail_count), 1);
    submit_wrong(222222);
    check("t5_fail2", int'(kp.fail_count), 2);
    submit_wrong(333333);
    check("t5_locked", int'(kp.locked), 1);
    check("t5_fail3", int'(kp.fail_count), 3);
    press(4'h1);
    press(4'h2);
    press(4'hB);
    verdict(1'b1, 1'b0);
    check("t5_keys_ignored", int'(kp.digit_count), 0);
    idle(27);
    check("t5_still_locked", int'(kp.locked), 1);
    idle(1);
    check("t5_unlocked", int'(kp.locked), 0);
    check("t5_fail_clr", int'(kp.fail_count), 0);
    type_number(424242, 6);
    press(4'hB);
    check("t5_fourth", int'(kp.pass_value), 424242);
    idle(1);
    verdict(1'b1, 1'b0);

    // Simultaneous verdicts resolve as ok
    submit_wrong(555555);
    type_number(654321, 6);
    press(4'hB);
    idle(1);
    verdict(1'b1, 1'b1);
    check("t6_ok_wins", int'(kp.fail_count), 0);

    // Asynchronous reset mid-entry
    type_number(12, 2);
    #2 rst_n = 1'b0;
    #1 check_reset_values("rst_entry");
    @(negedge clk);
    rst_n = 1'b1;
    idle(1);

    // Asynchronous reset mid-lockout
    submit_wrong(100000);
    submit_wrong(200000);
    submit_wrong(300000);
    idle(5);
    check("t6_lock_before_rst", int'(kp.locked), 1);
    #2 rst_n = 1'b0;
    #1 check_reset_values("rst_lock");
    @(negedge clk);
    rst_n = 1'b1;
    idle(2);
    type_number(999999, 6);
    press(4'hB);
    check("t6_after_rst", int'(kp.pass_value), 999999);
    idle(1);
    verdict(1'b1, 1'b0);
    idle(2);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/parking_keypad.md
Name: parking_keypad

Overview:
- Upstream entrance stage of the parking controller.
- Collects decimal key presses from the entrance keypad and accumulates them into a 20-bit binary password.
- Presents the password with a one-cycle submit strobe to the password checker, then waits for the checker's ok/wrong verdict.
- Enforces an entry timeout and a lockout after repeated wrong passwords.

Parameters:
DIGITS, 6, number of decimal digits in a complete password (1..6)
TIMEOUT_CYCLES, 1000, idle cycles allowed between key presses during entry and while waiting for a verdict
MAX_TRIES, 3, consecutive wrong verdicts that trigger lockout
LOCK_CYCLES, 5000, lockout duration in cycles

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
key_valid  input  1  one-cycle strobe: key_code is valid this cycle
key_code  input  4  0..9 = digit, 4'hA = clear, 4'hB = enter, 4'hC..4'hF = ignored
ok_pass  input  1  checker verdict: password accepted
wrong_pass  input  1  checker verdict: password rejected
pass_value  output  20  accumulated password, binary
pass_valid  output  1  one-cycle submit strobe to the checker
digit_count  output  3  digits entered so far (0..DIGITS)
entry_active  output  1  high in ENTRY, SUBMIT and WAIT_RESULT
entry_error  output  1  one-cycle pulse on short entry or timeout
locked  output  1  high throughout LOCKOUT
fail_count  output  2  consecutive wrong verdicts (0..MAX_TRIES)

Behaviour:
- Reset is asynchronous and active-low (rst_n). All state is updated on the rising edge of clk.
- Reset values: state = IDLE; pass_value = 0; pass_valid = 0; digit_count = 0; entry_active = 0; entry_error = 0; locked = 0; fail_count = 0; all counters = 0.
- Reset asserted mid-operation aborts everything immediately, including LOCKOUT.
- States: IDLE, ENTRY, SUBMIT, WAIT_RESULT, LOCKOUT.
- Accumulation: on each accepted digit d, pass_value <= pass_value*10 + d and digit_count increments. The maximum value 999999 fits in 20 bits, so no overflow is possible.
- IDLE:
  - Digit key -> ENTRY with pass_value = d and digit_count = 1.
  - Clear, enter and ignored codes keep the block in IDLE with no outputs changing.
- ENTRY:
  - Digit while digit_count < DIGITS: accumulate.
  - Digit while digit_count == DIGITS: discard; no change.
  - Clear: pass_value = 0, digit_count = 0 -> IDLE. No error pulse.
  - Enter with digit_count == DIGITS -> SUBMIT.
  - Enter with digit_count < DIGITS: clear, pulse entry_error -> IDLE. fail_count is unchanged.
  - Idle counter resets on every key_valid. When it reaches TIMEOUT_CYCLES with no key: clear, pulse entry_error -> IDLE.
- SUBMIT (one cycle):
  - pass_valid = 1 -> WAIT_RESULT.
  - pass_value is held stable from SUBMIT until WAIT_RESULT is exited.
- WAIT_RESULT:
  - All keys are ignored.
  - ok_pass: fail_count = 0, clear pass_value/digit_count -> IDLE.
  - wrong_pass: fail_count increments and the entry is cleared. If the new fail_count == MAX_TRIES -> LOCKOUT, else -> IDLE.
  - ok_pass and wrong_pass high in the same cycle: ok_pass wins.
  - No verdict within TIMEOUT_CYCLES: pulse entry_error, clear -> IDLE. fail_count is unchanged.
  - A verdict arriving in any other state is ignored.
- LOCKOUT:
  - locked = 1 and all keys are ignored.
  - After LOCK_CYCLES cycles: locked = 0, fail_count = 0 -> IDLE.
- Latency: enter accepted at cycle N -> pass_valid high at cycle N+1 -> earliest verdict sampled at N+2.
- key_valid is sampled only in IDLE and ENTRY. Upstream does not repeat keys; one strobe = one key.

Test Plan:
1. Keys 1,2,3,4,5,6, then enter -> pass_value = 20'd123456, pass_valid high for exactly 1 cycle, one cycle after enter. Then ok_pass -> IDLE, pass_value = 0, fail_count = 0.
2. Keys 9,8,7, then enter -> entry_error pulses 1 cycle, state IDLE, digit_count = 0, fail_count = 0. Seven digits 1..7 then enter -> submitted value 123456; the 7th digit is discarded.
3. Keys 5,5, then clear, then 0,0,0,0,0,1, then enter -> pass_value = 1.
4. With TIMEOUT_CYCLES = 16: key 4, then 16 idle cycles -> entry_error pulse, digit_count = 0. A later digit restarts entry cleanly.
5. With MAX_TRIES = 3 and LOCK_CYCLES = 32: three submits each answered by wrong_pass -> fail_count goes 1, 2, then locked = 1. Keys during lockout are ignored. locked falls after 32 cycles and fail_count = 0. A 4th entry then works.
6. Simultaneous ok_pass + wrong_pass in WAIT_RESULT -> treated as ok, fail_count = 0. Separately, rst_n pulsed low mid-entry and mid-lockout -> all outputs at reset values immediately, asynchronously.
